// File: rtl/racing_pkg.sv
// Shared definitions for the racing game datapath: paddle FSM encoding,
// paddle position constants and the rounding average used when smoothing.
package racing_pkg;

  typedef enum logic [1:0] {
    PADDLE_IDLE     = 2'd0,
    PADDLE_ARMED    = 2'd1,
    PADDLE_CAPTURED = 2'd2
  } paddle_state_e;

  localparam logic [7:0] PADDLE_RESET_POS = 8'd128;
  localparam logic [7:0] PADDLE_TIMEOUT   = 8'hFF;

  // Sum is kept at 9 bits so 255 averaged with 255 stays 255.
  function automatic logic [7:0] paddle_round_avg(input logic [7:0] a,
                                                  input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    return sum[8:1];
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle axis: synchronises the comparator, filters the first low scanline
// of the frame and commits the (optionally smoothed) position at vsync.
module paddle_channel
  import racing_pkg::*;
#(
  parameter int         FILTER_LINES = 2,
  parameter bit         SMOOTH       = 1'b1,
  parameter logic [7:0] TIMEOUT_VAL  = PADDLE_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          paddle,
  input  logic          hs_rise,
  input  logic          vs_rise,
  input  logic [8:0]    vpos,
  output logic [7:0]    pos,
  output logic          timeout,
  output paddle_state_e state
);

  localparam logic [2:0] FILT = 3'(FILTER_LINES);

  logic       p_s1;
  logic       p_s2;
  logic [2:0] lowcnt;
  logic [7:0] cand;
  logic [7:0] pending;
  logic [7:0] commit_val;
  logic [7:0] first_pos;
  logic [7:0] next_pos;
  logic       sample_ok;

  assign commit_val = (state == PADDLE_CAPTURED) ? pending : TIMEOUT_VAL;
  assign next_pos   = SMOOTH ? paddle_round_avg(pos, commit_val) : commit_val;
  // Lines 256 and up are outside the playfield; their samples are skipped.
  assign sample_ok  = hs_rise & ~vpos[8];
  // With a one-line filter the candidate register is not yet loaded.
  assign first_pos  = (lowcnt == 3'd0) ? vpos[7:0] : cand;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_s1    <= 1'b0;
      p_s2    <= 1'b0;
      lowcnt  <= 3'd0;
      cand    <= 8'd0;
      pending <= 8'd0;
      pos     <= PADDLE_RESET_POS;
      timeout <= 1'b0;
      state   <= PADDLE_IDLE;
    end else begin
      p_s1 <= paddle;
      p_s2 <= p_s1;
      case (state)
        PADDLE_IDLE: begin
          if (vs_rise) begin
            state  <= PADDLE_ARMED;
            lowcnt <= 3'd0;
          end
        end
        PADDLE_ARMED: begin
          // vs_rise wins over a coincident hs_rise; that line's sample is dropped.
          if (vs_rise) begin
            pos     <= next_pos;
            timeout <= 1'b1;
            lowcnt  <= 3'd0;
          end else if (sample_ok) begin
            if (!p_s2) begin
              if (lowcnt == 3'd0) cand <= vpos[7:0];
              if (lowcnt + 3'd1 == FILT) begin
                pending <= first_pos;
                lowcnt  <= 3'd0;
                state   <= PADDLE_CAPTURED;
              end else begin
                lowcnt <= lowcnt + 3'd1;
              end
            end else begin
              lowcnt <= 3'd0;
            end
          end
        end
        PADDLE_CAPTURED: begin
          if (vs_rise) begin
            pos     <= next_pos;
            timeout <= 1'b0;
            lowcnt  <= 3'd0;
            state   <= PADDLE_ARMED;
          end
        end
        default: state <= PADDLE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/paddle_digitizer.sv
// Digitises both analog paddles into per-frame 8-bit positions; shares the
// hsync/vsync edge detectors and issues one valid pulse per commit.
module paddle_digitizer
  import racing_pkg::*;
#(
  parameter int         FILTER_LINES = 2,
  parameter bit         SMOOTH       = 1'b1,
  parameter logic [7:0] TIMEOUT_VAL  = PADDLE_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hpaddle,
  input  logic       vpaddle,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [8:0] vpos,
  output logic [7:0] paddle_x,
  output logic [7:0] paddle_y,
  output logic       paddle_valid,
  output logic [1:0] paddle_timeout
);

  logic          hsync_q;
  logic          vsync_q;
  logic          hs_rise;
  logic          vs_rise;
  logic          x_timeout;
  logic          y_timeout;
  paddle_state_e x_state;
  paddle_state_e y_state;

  assign hs_rise        = hsync & ~hsync_q;
  assign vs_rise        = vsync & ~vsync_q;
  assign paddle_timeout = {y_timeout, x_timeout};

  // Both channels arm on the same vs_rise, so either being out of IDLE means a commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      paddle_valid <= 1'b0;
    end else begin
      hsync_q      <= hsync;
      vsync_q      <= vsync;
      paddle_valid <= vs_rise & ((x_state != PADDLE_IDLE) | (y_state != PADDLE_IDLE));
    end
  end

  paddle_channel #(
    .FILTER_LINES(FILTER_LINES),
    .SMOOTH      (SMOOTH),
    .TIMEOUT_VAL (TIMEOUT_VAL)
  ) u_x (
    .clk    (clk),
    .reset  (reset),
    .paddle (hpaddle),
    .hs_rise(hs_rise),
    .vs_rise(vs_rise),
    .vpos   (vpos),
    .pos    (paddle_x),
    .timeout(x_timeout),
    .state  (x_state)
  );

  paddle_channel #(
    .FILTER_LINES(FILTER_LINES),
    .SMOOTH      (SMOOTH),
    .TIMEOUT_VAL (TIMEOUT_VAL)
  ) u_y (
    .clk    (clk),
    .reset  (reset),
    .paddle (vpaddle),
    .hs_rise(hs_rise),
    .vs_rise(vs_rise),
    .vpos   (vpos),
    .pos    (paddle_y),
    .timeout(y_timeout),
    .state  (y_state)
  );

endmodule

// File: doc/paddle_digitizer.md
Name: paddle_digitizer

Overview:
- Upstream stage for the racing game's player and speed logic. Converts the two analog-paddle comparator inputs, hpaddle and vpaddle, into clean 8-bit positions.
- Each paddle is measured as the scanline on which its comparator first goes low within a frame.
- Positions are committed once per frame at vsync, with glitch filtering and optional smoothing.
- Replaces raw per-hsync paddle sampling. Outputs feed the per-frame player_x and speed update logic.

Parameters:
FILTER_LINES, 2, consecutive hsync samples the comparator must read low before a capture is accepted (1..7)
SMOOTH, 1, 1 = committed value is the rounded average of the old and new measurement; 0 = raw measurement
TIMEOUT_VAL, 8'hFF, value committed when no capture occurred in the frame

Ports:
clk  input  1  pixel clock, same clock as hvsync_generator
reset  input  1  asynchronous, active-low reset
hpaddle  input  1  horizontal paddle comparator, asynchronous, active-low "reached"
vpaddle  input  1  vertical paddle comparator, asynchronous, active-low "reached"
hsync  input  1  from hvsync_generator, clk domain
vsync  input  1  from hvsync_generator, clk domain
vpos  input  9  current scanline from hvsync_generator
paddle_x  output  8  committed hpaddle position
paddle_y  output  8  committed vpaddle position
paddle_valid  output  1  one-clk pulse on every commit
paddle_timeout  output  2  {y,x}: 1 = last commit for that channel was TIMEOUT_VAL

Behaviour:
- **Reset** (reset low, asynchronous; all state clears immediately):
  - paddle_x = paddle_y = 8'd128, paddle_valid = 0, paddle_timeout = 2'b00.
  - Both channels go to IDLE; sync flops, edge registers and filter counters clear.
- **Synchronisation:** hpaddle and vpaddle pass through a 2-flop synchroniser. Only synchronised values are used.
- **Edge detection:** hsync and vsync are registered once. hs_rise = hsync & ~hsync_q; vs_rise = vsync & ~vsync_q.
- **Channel FSM** (identical per channel), states IDLE, ARMED, CAPTURED:
  - IDLE: on vs_rise -> ARMED, with lowcnt = 0. No commit occurs on this edge.
  - ARMED:
    - On hs_rise with vpos[8]=0 and synced paddle low: lowcnt++. On the first low, cand = vpos[7:0].
    - When lowcnt reaches FILTER_LINES: pending = cand, go to CAPTURED.
    - On hs_rise with paddle high: lowcnt = 0. cand is overwritten by the next low.
    - On vs_rise: commit TIMEOUT_VAL, set timeout bit = 1, stay ARMED with lowcnt = 0.
  - CAPTURED: ignore hs_rise. On vs_rise: commit pending, set timeout bit = 0, go to ARMED with lowcnt = 0.
- **vpos range:** hs_rise with vpos[8]=1 (lines 256+) is ignored, and lowcnt is held.
- **Simultaneous edges:** if hs_rise and vs_rise occur in the same cycle, vs_rise is processed and the hsync sample is discarded.
- **Commit arithmetic:**
  - SMOOTH=1: out <= (out + new + 1) >> 1, computed in 9 bits. No overflow; 255 and 255 give 255.
  - SMOOTH=0: out <= new.
- **Latency:** vs_rise is detected in cycle N. paddle_x, paddle_y, paddle_timeout and paddle_valid all update at the clock edge ending cycle N, i.e. they are visible in cycle N+1.
  - paddle_valid is high for exactly that one cycle.
  - Both channels commit in the same cycle, so there is a single valid pulse.
- **Reset mid-frame:** the first commit after reset release happens on the second vs_rise. The first vs_rise only arms the channels.
- No other outputs change between commits.

Decomposition:
- Shared package racing_pkg:
  - paddle FSM state encoding (IDLE=2'd0, ARMED=2'd1, CAPTURED=2'd2)
  - PADDLE_RESET_POS = 8'd128
  - PADDLE_TIMEOUT = 8'hFF
- Sub-module paddle_channel, instantiated twice (x and y). It contains the synchroniser, filter counter, FSM, pending register and smoothing output register.
- The top level holds the hsync/vsync edge detectors and paddle_valid.

Test Plan:
- Release reset, hold hpaddle low from line 40 onward, vpaddle never low, SMOOTH=0 -> no valid on the 1st vsync. On the 2nd vsync: paddle_x=40, paddle_y=255, paddle_timeout=2'b10, paddle_valid high for 1 clk.
- FILTER_LINES=2, hpaddle low on line 30 only, then continuously from line 50 -> committed paddle_x=50 (the single-line glitch is rejected).
- SMOOTH=1, previous paddle_x=100, new capture 51 -> paddle_x=76; repeat with 255 and 255 -> paddle_x=255.
- Force hs_rise and vs_rise in the same cycle while ARMED with paddle low -> lowcnt stays 0, and the commit is TIMEOUT_VAL if nothing was captured.
- Paddle low only during lines 256-261 -> ignored; commit 255 with timeout=1.
- Assert reset mid-frame after a capture at line 60 -> outputs return to 128 immediately, the next vsync gives no valid, and the following vsync commits the new measurement.
